instr_encoder: RTL
==================

# instr_encoder

Streaming RV32I instruction encoder and program writer: the inverse of the instruction field decoder. It accepts decoded fields plus a full immediate over a valid/ready handshake and packs them into a 32-bit word according to the opcode's format. Each word is written to sequential addresses of an instruction-memory write port. It sits between the test/loader logic and the instruction memory of the single-cycle CPU.

## Interface
- `ADDR_W`, 8: memory word-address width; depth is 2^ADDR_W.
- `BASE_ADDR`, 0: first word address written after reset or restart.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous; address returns to BASE_ADDR, pending word dropped, full and err cleared.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  bundle accepted when in_valid && in_ready.
- `op`  in  7  opcode.
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `func3`  in  3  funct3.
- `func7`  in  7  funct7.
- `imm`  in  32  sign-extended immediate; format slicing is done internally.
- `mem_we`  out  1  write request; held until mem_ready.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  ADDR_W  word address of the pending write.
- `mem_wdata`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  words written since reset/restart.
- `full`  out  1  last address written; no further input accepted.
- `err`  out  1  sticky unknown-opcode flag (see Configuration).

## Operation
- One-entry output register with states EMPTY (mem_we=0) and PENDING (mem_we=1).
- `in_ready = !full && !restart && (!pending || mem_ready)`.
- On accept: encode combinationally, register into mem_wdata, go to PENDING; mem_addr = next address.
- On mem_ready in PENDING: word is written, count increments, next address increments. If no new accept that cycle, go to EMPTY.
- Encoding rules: `op` maps to a format; all other fields are ignored.
  - R (0110011): {func7, rs2, rs1, func3, rd, op}.
  - I (0010011, 0000011, 1100111, 1110011): {imm[11:0], rs1, func3, rd, op}.
    - Exception: op 0010011 with func3 001 or 101 packs as {func7, imm[4:0], rs1, func3, rd, op}.
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - U (0110111, 0010111): {imm[31:12], rd, op}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Full: after the write to address 2^ADDR_W-1 completes, full=1. Further writes and accepts are blocked, the address does not wrap, and count holds at 2^ADDR_W - BASE_ADDR.
- restart has priority over accept and over mem_ready. The pending word is discarded and not counted.

## Timing
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0. in_ready=1 after reset.
- Latency: accept at edge N gives mem_we=1 with valid data after edge N.
- Throughput: one word per cycle while mem_ready stays high.
- mem_addr and mem_wdata are stable while mem_we=1 and mem_ready=0.
- Reset asserted mid-write drops the pending word immediately.

## Configuration
- `INSTR_ENCODER_CHECK_EN` defined:
  - An opcode outside the listed set encodes as NOP 0x00000013.
  - err sets the cycle after that accept and stays set until rst or restart.
- Macro undefined:
  - Unknown opcodes pack as R format.
  - err is tied to 0.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - NOP constant;
  - a format enum (FMT_R/I/S/B/U/J/BAD).
- One combinational sub-module, `instr_pack`, holds the opcode-to-format mapping and bit packing. The top holds the handshake, address counter and flags.

## Test plan
- R format, mem_ready=1: add x3,x1,x2 (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0) -> mem_wdata 0x002081B3 at addr 0, count=1.
- I and U formats, back-to-back with no bubble:
  - addi x1,x0,5 -> 0x00500093;
  - lui x5 with imm 0x12345000 -> 0x123452B7;
  - expect addresses 0 then 1.
- S, B and J formats:
  - sw x2,8(x1) -> 0x0020A423;
  - beq x1,x2 with imm -4 -> 0xFE208EE3;
  - jal x1 with imm 8 -> 0x008000EF.
- Backpressure: mem_ready=0 for 3 cycles -> mem_we, mem_addr and mem_wdata held, in_ready=0. Release mem_ready -> write completes and count increments once.
- Full and restart:
  - ADDR_W=2, 4 writes -> full=1, in_ready=0, count=4;
  - restart -> mem_addr=0, count=0, full=0.
- Check macro on: op 0x7F -> 0x00000013, err=1 from the next cycle; restart clears err.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcode constants, instruction formats and opcode-to-format lookup.
package rv32i_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;
  function automatic fmt_e op_fmt(input logic [6:0] op);
    return (op == OP_R) ? FMT_R :
           (op inside {OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM}) ? FMT_I :
           (op == OP_STORE) ? FMT_S :
           (op == OP_BRANCH) ? FMT_B :
           (op inside {OP_LUI, OP_AUIPC}) ? FMT_U :
           (op == OP_JAL) ? FMT_J : FMT_BAD;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs decoded RV32I fields into a 32-bit word by opcode format.
// INSTR_ENCODER_CHECK_EN: unknown opcodes become NOP and raise o_bad; otherwise they pack as R.
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [6:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_func7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_bad
);
  fmt_e        w_fmt;
  logic        w_shamt;
  logic [31:0] w_r;
  logic [31:0] w_i;
  logic [31:0] w_dflt;
  assign w_fmt   = op_fmt(i_op);
  assign w_shamt = i_op == OP_IMM && (i_func3 == 3'b001 || i_func3 == 3'b101);
  assign w_r     = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_op};
  // Shift-immediates carry funct7 in the upper bits and only a 5-bit shamt.
  assign w_i     = w_shamt ? {i_func7, i_imm[4:0], i_rs1, i_func3, i_rd, i_op}
                           : {i_imm[11:0], i_rs1, i_func3, i_rd, i_op};
`ifdef INSTR_ENCODER_CHECK_EN
  assign o_bad  = w_fmt == FMT_BAD;
  assign w_dflt = NOP;
`else
  assign o_bad  = 1'b0;
  assign w_dflt = w_r;
`endif
  assign o_word = (w_fmt == FMT_R) ? w_r :
                  (w_fmt == FMT_I) ? w_i :
                  (w_fmt == FMT_S) ? {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_op} :
                  (w_fmt == FMT_B) ? {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3, i_imm[4:1], i_imm[11], i_op} :
                  (w_fmt == FMT_U) ? {i_imm[31:12], i_rd, i_op} :
                  (w_fmt == FMT_J) ? {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op} :
                  w_dflt;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams encoded RV32I words into sequential instruction-memory addresses.
// INSTR_ENCODER_CHECK_EN (in instr_pack) enables the sticky unknown-opcode err flag.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;
  logic [31:0]       w_word;
  logic              w_bad;
  logic              w_acc;
  logic              w_wr;
  logic              r_pend;
  logic              r_full;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  instr_pack u_pack (
    .i_op(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_func3(func3),
    .i_func7(func7), .i_imm(imm), .o_word(w_word), .o_bad(w_bad)
  );
  // A word pending for the last address has nowhere to go after it, so hold off accepts.
  assign in_ready  = !r_full && !restart && !(r_pend && r_addr == LAST) && (!r_pend || mem_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_wr      = r_pend && mem_ready;
  assign mem_we    = r_pend;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_count <= '0;
    end else if (restart) begin
      r_pend  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= BASE;
      r_count <= '0;
    end else begin
      r_pend <= w_acc || (r_pend && !mem_ready);
      if (w_acc) r_wdata <= w_word;
      if (w_acc && w_bad) r_err <= 1'b1;
      if (w_wr) begin
        r_count <= r_count + (ADDR_W+1)'(1);
        r_full  <= r_addr == LAST;
        r_addr  <= (r_addr == LAST) ? r_addr : r_addr + ADDR_W'(1);
      end
    end
  end
endmodule
